// File: rtl/lane_dispatch_seq_pkg.sv
// ============================================================================
// cnn_dispatch_pkg : shared types and helpers for the lane dispatch sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package cnn_dispatch_pkg;

  localparam int LANES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } dispatch_state_t;

  function automatic logic [LANES-1:0] lane_onehot(input logic [1:0] lane);
    lane_onehot = 4'b0001 << lane;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lane_dispatch_seq_if.sv
// ============================================================================
// lane_dispatch_seq_if : pixel stream in, demux/FIFO-write side out
// Rev 1.0
// ============================================================================
`default_nettype none

interface lane_dispatch_seq_if
  import cnn_dispatch_pkg::*;
#(
  parameter int SIZE = 8
) ();

  logic             s_valid;
  logic             s_ready;
  logic [SIZE-1:0]  s_data;
  logic             s_last;
  logic [LANES-1:0] lane_full;
  logic [1:0]       sel;
  logic [SIZE-1:0]  d_out;
  logic [LANES-1:0] lane_we;
  logic             frame_done;

  modport master (
    output s_valid, s_data, s_last, lane_full,
    input  s_ready, sel, d_out, lane_we, frame_done
  );

  modport slave (
    input  s_valid, s_data, s_last, lane_full,
    output s_ready, sel, d_out, lane_we, frame_done
  );

endinterface

`default_nettype wire

// File: rtl/lane_dispatch_seq_lane_col_counter.sv
// ============================================================================
// lane_col_counter : column counter within a row, lane counter wrapping 3->0
// Rev 1.0
// ============================================================================
`default_nettype none

module lane_col_counter #(
  parameter  int ROW_LEN = 16,
  localparam int COL_W   = $clog2(ROW_LEN)
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             step,
  input  wire logic             clear,
  output logic      [COL_W-1:0] col,
  output logic      [1:0]       lane,
  output logic                  row_end
);

  logic [COL_W-1:0] r_col;
  logic [1:0]       r_lane;
  logic             w_row_end;

  assign w_row_end = (r_col == COL_W'(ROW_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= '0;
      r_lane <= '0;
    end else if (clear) begin
      r_col  <= '0;
      r_lane <= '0;
    end else if (step) begin
      if (w_row_end) begin
        r_col  <= '0;
        r_lane <= r_lane + 2'd1;
      end else begin
        r_col  <= r_col + COL_W'(1);
      end
    end
  end

  assign col     = r_col;
  assign lane    = r_lane;
  assign row_end = w_row_end;

endmodule

`default_nettype wire

// File: rtl/lane_dispatch_seq.sv
// ============================================================================
// lane_dispatch_seq : feeds the 1:4 lane demux, ROW_LEN pixels per lane row,
// zero-pads a short final row. Optional stats via DISPATCH_STATS_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module lane_dispatch_seq
  import cnn_dispatch_pkg::*;
#(
  parameter  int SIZE    = 8,
  parameter  int ROW_LEN = 16,
  localparam int COL_W   = $clog2(ROW_LEN)
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  lane_dispatch_seq_if.slave bus
`ifdef DISPATCH_STATS_EN
  ,
  output logic [15:0]    stall_cnt,
  output logic [15:0]    frame_cnt
`endif
);

  dispatch_state_t  r_state;
  logic [1:0]       r_sel;
  logic [SIZE-1:0]  r_d_out;
  logic [LANES-1:0] r_lane_we;
  logic             r_frame_done;

  logic [COL_W-1:0] w_col;
  logic [1:0]       w_lane;
  logic             w_row_end;
  logic             w_idle_run;
  logic             w_ready;
  logic             w_accept;
  logic             w_pad;

  assign w_idle_run = (r_state == IDLE) || (r_state == RUN);
  // Only the current lane's full flag matters; s_ready held low during reset.
  assign w_ready    = rst_n & w_idle_run & ~bus.lane_full[w_lane];
  assign w_accept   = bus.s_valid & w_ready;
  assign w_pad      = (r_state == FLUSH) & ~bus.lane_full[w_lane];

  lane_col_counter #(
    .ROW_LEN (ROW_LEN)
  ) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .step    (w_accept | w_pad),
    .clear   (r_state == DONE),
    .col     (w_col),
    .lane    (w_lane),
    .row_end (w_row_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_sel        <= '0;
      r_d_out      <= '0;
      r_lane_we    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_lane_we    <= '0;
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE, RUN: begin
          if (w_accept) begin
            r_d_out   <= bus.s_data;
            r_sel     <= w_lane;
            r_lane_we <= lane_onehot(w_lane);
            if (bus.s_last) r_state <= w_row_end ? DONE : FLUSH;
            else            r_state <= RUN;
          end
        end
        FLUSH: begin
          if (w_pad) begin
            r_d_out   <= '0;
            r_sel     <= w_lane;
            r_lane_we <= lane_onehot(w_lane);
            if (w_row_end) r_state <= DONE;
          end
        end
        DONE: begin
          r_frame_done <= 1'b1;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef DISPATCH_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_frame_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (bus.s_valid && !w_ready && w_idle_run && (r_stall_cnt != 16'hFFFF))
        r_stall_cnt <= r_stall_cnt + 16'd1;
      if (r_state == DONE)
        r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign frame_cnt = r_frame_cnt;
`endif

  assign bus.s_ready    = w_ready;
  assign bus.sel        = r_sel;
  assign bus.d_out      = r_d_out;
  assign bus.lane_we    = r_lane_we;
  assign bus.frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_lane_dispatch_seq.sv
// ============================================================================
// tb_lane_dispatch_seq : directed self-checking bench for lane_dispatch_seq
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lane_dispatch_seq;

  localparam int SIZE    = 8;
  localparam int ROW_LEN = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  lane_dispatch_seq_if #(.SIZE(SIZE)) bus ();

`ifdef DISPATCH_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] frame_cnt;
`endif

  lane_dispatch_seq #(
    .SIZE    (SIZE),
    .ROW_LEN (ROW_LEN)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef DISPATCH_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .frame_cnt (frame_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One accepted pixel: s_ready high before the edge, write visible after it.
  task automatic beat(input logic [7:0] d, input logic last, input int lane, input string tag);
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    #1;
    check({tag, ".rdy"}, 32'(bus.s_ready), 32'd1);
    @(posedge clk); #1;
    check({tag, ".we"},   32'(bus.lane_we), 32'(1 << lane));
    check({tag, ".sel"},  32'(bus.sel),     32'(lane));
    check({tag, ".dout"}, 32'(bus.d_out),   32'(d));
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic stall(input logic [3:0] full, input int n, input logic [7:0] hold, input string tag);
    bus.lane_full = full;
    bus.s_valid   = 1'b1;
    bus.s_data    = 8'hAA;
    bus.s_last    = 1'b0;
    repeat (n) begin
      #1;
      check({tag, ".rdy"}, 32'(bus.s_ready), 32'd0);
      @(posedge clk); #1;
      check({tag, ".we"},   32'(bus.lane_we), 32'd0);
      check({tag, ".hold"}, 32'(bus.d_out),   32'(hold));
    end
    bus.lane_full = 4'b0000;
    bus.s_valid   = 1'b0;
  endtask

  task automatic expect_done(input string tag);
    #1;
    check({tag, ".done_rdy"}, 32'(bus.s_ready), 32'd0);
    check({tag, ".fd_early"}, 32'(bus.frame_done), 32'd0);
    @(posedge clk); #1;
    check({tag, ".fd"},    32'(bus.frame_done), 32'd1);
    check({tag, ".fd_we"}, 32'(bus.lane_we),    32'd0);
    @(posedge clk); #1;
    check({tag, ".fd_off"}, 32'(bus.frame_done), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.s_last    = 1'b0;
    bus.lane_full = 4'b0000;

    // Reset state
    #1;
    check("rst.rdy",  32'(bus.s_ready),    32'd0);
    check("rst.we",   32'(bus.lane_we),    32'd0);
    check("rst.sel",  32'(bus.sel),        32'd0);
    check("rst.dout", 32'(bus.d_out),      32'd0);
    check("rst.fd",   32'(bus.frame_done), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Full 64-pixel frame, four complete rows
    for (int i = 0; i < 64; i++)
      beat(8'(i * 3 + 1), i == 63, i / 16, "t1");
    expect_done("t1");

    // Backpressure on lane 1; other lanes' full flags ignored
    for (int i = 0; i < 19; i++)
      beat(8'(8'h40 + i), 1'b0, i / 16, "t2");
    bus.lane_full = 4'b1101;
    beat(8'h53, 1'b0, 1, "t2.other_full");
    bus.lane_full = 4'b0000;
    stall(4'b0010, 3, 8'h53, "t2.stall");
    for (int i = 20; i < 35; i++)
      beat(8'(8'h40 + i), 1'b0, i / 16, "t2");

    // Async reset mid-row on lane 2
    #1;
    bus.s_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t5.we",   32'(bus.lane_we), 32'd0);
    check("t5.sel",  32'(bus.sel),     32'd0);
    check("t5.dout", 32'(bus.d_out),   32'd0);
    check("t5.rdy",  32'(bus.s_ready), 32'd0);
`ifdef DISPATCH_STATS_EN
    check("t5.stall_cnt", 32'(stall_cnt), 32'd0);
    check("t5.frame_cnt", 32'(frame_cnt), 32'd0);
`endif
    bus.s_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    beat(8'h77, 1'b0, 0, "t5.first");

    // Short final row: 5 pixels then 11 pads to lane 0
    for (int i = 0; i < 4; i++)
      beat(8'(8'h51 + i), i == 3, 0, "t3");
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hEE;
    for (int p = 0; p < 11; p++) begin
      #1;
      check("t3.pad_rdy", 32'(bus.s_ready), 32'd0);
      @(posedge clk); #1;
      check("t3.pad_we",   32'(bus.lane_we), 32'd1);
      check("t3.pad_dout", 32'(bus.d_out),   32'd0);
      check("t3.pad_sel",  32'(bus.sel),     32'd0);
    end
    bus.s_valid = 1'b0;
    expect_done("t3");

    // 80 pixels: fifth row wraps back to lane 0; stall of 3 cycles on lane 1
    for (int i = 0; i < 80; i++) begin
      if (i == 20) stall(4'b0010, 3, 8'(19 + 7), "t4.stall");
      beat(8'(i + 7), i == 79, (i / 16) % 4, "t4");
    end
    expect_done("t4");

`ifdef DISPATCH_STATS_EN
    check("t6.stall_cnt", 32'(stall_cnt), 32'd3);
    check("t6.frame_cnt", 32'(frame_cnt), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
